// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM and the ALU control stage:
// state encoding, opcode constants, alu_op codes and the control-word bundle.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b100;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control-word table for the multicycle control FSM.
// Ports: state, op_andi (latched op is ANDI), op_legal (live opcode
// supported), mem_ready, force_off (reset gate) -> ctrl bundle.
module mc_ctrl_decode
    import mc_control_fsm_pkg::*;
(
    input  state_t state,
    input  logic   op_andi,
    input  logic   op_legal,
    input  logic   mem_ready,
    input  logic   force_off,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (!force_off) begin
            unique case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.alu_op    = ALU_ADD;
                    // IR and PC only update once the fetch really completes
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = 2'b11;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.illegal_op = !op_legal;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b00;
                    ctrl.alu_op    = ALU_RTYPE;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = 2'b01;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = 2'b10;
                end
                S_I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                    ctrl.alu_op    = op_andi ? ALU_AND : ALU_ADD;
                end
                S_I_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM: state register, opcode latch and
// next-state logic. Ports: clk, rst, opcode, mem_ready in; datapath
// controls, alu_op, illegal_op pulse and state_dbg out.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_ANDI  = 6'b001100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       op_legal;
    ctrl_t      ctrl;

    assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW)
                   || (opcode == OP_SW)    || (opcode == OP_BEQ)
                   || (opcode == OP_J)     || (opcode == OP_ADDI)
                   || (opcode == OP_ANDI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            // later states decode only this copy, never the live input
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                unique case (1'b1)
                    (opcode == OP_LW),
                    (opcode == OP_SW):    state_d = S_MEM_ADDR;
                    (opcode == OP_RTYPE): state_d = S_R_EXEC;
                    (opcode == OP_BEQ):   state_d = S_BRANCH;
                    (opcode == OP_J):     state_d = S_JUMP;
                    (opcode == OP_ADDI),
                    (opcode == OP_ANDI):  state_d = S_I_EXEC;
                    default:              state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .op_andi   (op_q == OP_ANDI),
        .op_legal  (op_legal),
        .mem_ready (mem_ready),
        .force_off (rst),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign illegal_op    = ctrl.illegal_op;
    // reset reads as FETCH immediately, before the first clock edge
    assign state_dbg     = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: directed instruction sequences plus
// randomized instructions and memory waits against a step-list model.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    wire [17:0] obs = {pc_write, pc_write_cond, i_or_d, mem_read,
                       mem_write, ir_write, mem_to_reg, reg_write,
                       reg_dst, alu_src_a, alu_src_b, pc_source,
                       alu_op, illegal_op};

    // instruction steps as the bench sees them
    localparam int K_F = 0, K_D = 1, K_MA = 2, K_MR = 3, K_MWB = 4;
    localparam int K_MW = 5, K_RE = 6, K_RWB = 7, K_BR = 8, K_J = 9;
    localparam int K_IE = 10, K_IWB = 11;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00;
    localparam logic [5:0] BEQ = 6'h04, JMP = 6'h02;
    localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0c;

    int n_vec = 0;
    int n_err = 0;
    int plan_q[$];

    function automatic logic [17:0] ctl(input int k, input logic [5:0] op,
                                        input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa, ill;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0;
        m2r = 0; rw = 0; rd = 0; sa = 0; ill = 0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (k)
            K_F:   begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            K_D:   begin
                sb = 2'b11;
                ill = !(op inside {LW, SW, RT, BEQ, JMP, ADDI, ANDI});
            end
            K_MA:  begin sa = 1; sb = 2'b10; end
            K_MR:  begin mr = 1; iod = 1; end
            K_MWB: begin rw = 1; m2r = 1; end
            K_MW:  begin mw = 1; iod = 1; end
            K_RE:  begin sa = 1; ao = 3'b100; end
            K_RWB: begin rw = 1; rd = 1; end
            K_BR:  begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
            K_J:   begin pw = 1; ps = 2'b10; end
            K_IE:  begin
                sa = 1; sb = 2'b10;
                ao = (op == ANDI) ? 3'b011 : 3'b000;
            end
            K_IWB: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa, sb, ps, ao, ill};
    endfunction

    task automatic build_plan(input logic [5:0] op);
        plan_q.delete();
        plan_q.push_back(K_F);
        plan_q.push_back(K_D);
        case (op)
            LW:         begin plan_q.push_back(K_MA); plan_q.push_back(K_MR);
                              plan_q.push_back(K_MWB); end
            SW:         begin plan_q.push_back(K_MA); plan_q.push_back(K_MW); end
            RT:         begin plan_q.push_back(K_RE); plan_q.push_back(K_RWB); end
            BEQ:        plan_q.push_back(K_BR);
            JMP:        plan_q.push_back(K_J);
            ADDI, ANDI: begin plan_q.push_back(K_IE); plan_q.push_back(K_IWB); end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic r, input logic [5:0] opv, input logic rdy,
                       input logic [17:0] exp, input logic exp_fetch,
                       input string tag);
        @(negedge clk);
        rst = r;
        opcode = opv;
        mem_ready = rdy;
        #1;
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp);
        end
        n_vec++;
        assert ((state_dbg == 4'd0) === exp_fetch) else begin
            n_err++;
            $error("FAIL %s fetch_state observed=%0d expected=%0d dbg=%0d",
                   tag, state_dbg == 4'd0, exp_fetch, state_dbg);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input string tag);
        int steps[$];
        build_plan(op);
        steps = plan_q;
        foreach (steps[i]) begin
            int k;
            int waits;
            logic [5:0] rop;
            logic rr;
            k = steps[i];
            waits = (k == K_F) ? fw : ((k == K_MR || k == K_MW) ? mw : 0);
            for (int w = 0; w < waits; w++) begin
                rop = 6'($urandom);
                cyc(1'b0, rop, 1'b0, ctl(k, op, 1'b0), k == K_F, tag);
            end
            rop = (k == K_D) ? op : 6'($urandom);
            rr = (k == K_F || k == K_MR || k == K_MW) ? 1'b1 : 1'($urandom);
            cyc(1'b0, rop, rr, ctl(k, op, 1'b1), k == K_F, tag);
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{LW, SW, RT, BEQ, JMP, ADDI, ANDI};
        rst = 1'b1;
        opcode = '0;
        mem_ready = 1'b0;

        repeat (3) cyc(1'b1, 6'($urandom), 1'($urandom), '0, 1'b1, "reset");

        run_instr(LW,   0, 0, "lw");
        run_instr(SW,   0, 3, "sw_wait");
        run_instr(RT,   1, 0, "rtype");
        run_instr(BEQ,  0, 0, "beq");
        run_instr(ANDI, 0, 0, "andi");
        run_instr(ADDI, 2, 0, "addi");
        run_instr(JMP,  0, 0, "j");
        run_instr(6'h3f, 0, 0, "illegal");
        run_instr(LW,   0, 2, "lw_wait");

        // reset while waiting in MEM_RD
        cyc(1'b0, 6'h15, 1'b1, ctl(K_F, LW, 1'b1), 1'b1, "rst_mrd");
        cyc(1'b0, LW, 1'b0, ctl(K_D, LW, 1'b0), 1'b0, "rst_mrd");
        cyc(1'b0, 6'h2a, 1'b0, ctl(K_MA, LW, 1'b0), 1'b0, "rst_mrd");
        cyc(1'b0, 6'h07, 1'b0, ctl(K_MR, LW, 1'b0), 1'b0, "rst_mrd");
        cyc(1'b0, 6'h11, 1'b0, ctl(K_MR, LW, 1'b0), 1'b0, "rst_mrd");
        repeat (3) cyc(1'b1, 6'($urandom), 1'($urandom), '0, 1'b1, "rst_hold");
        run_instr(RT, 0, 0, "after_rst");

        // reset while waiting in MEM_WR
        cyc(1'b0, 6'h01, 1'b1, ctl(K_F, SW, 1'b1), 1'b1, "rst_mwr");
        cyc(1'b0, SW, 1'b1, ctl(K_D, SW, 1'b1), 1'b0, "rst_mwr");
        cyc(1'b0, LW, 1'b1, ctl(K_MA, SW, 1'b1), 1'b0, "rst_mwr");
        cyc(1'b0, LW, 1'b0, ctl(K_MW, SW, 1'b0), 1'b0, "rst_mwr");
        cyc(1'b1, LW, 1'b1, '0, 1'b1, "rst_mwr_hold");
        run_instr(BEQ, 0, 0, "after_rst2");

        repeat (80) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL expose these ports, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE only.
- mem_ready  in  1  memory completion handshake for the current access.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  out  3  feeds the ALU control stage: 000 add, 001 sub, 011 and, 100 R-type (funct decode).
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_dbg  out  4  current state encoding.
REQ-002 Parameters SHALL be, one per line:
- OP_RTYPE 6'b000000
- OP_LW 6'b100011
- OP_SW 6'b101011
- OP_BEQ 6'b000100
- OP_J 6'b000010
- OP_ADDI 6'b001000
- OP_ANDI 6'b001100

Function
REQ-003 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB.
REQ-004 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000 and pc_source=00, and SHALL assert ir_write and pc_write only while mem_ready=1. It SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=000. Next state: LW/SW -> MEM_ADDR, RTYPE -> R_EXEC, BEQ -> BRANCH, J -> JUMP, ADDI/ANDI -> I_EXEC, any other opcode -> FETCH with illegal_op=1 for this cycle only.
REQ-006 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000. Next state: LW -> MEM_RD, SW -> MEM_WR.
REQ-007 MEM_RD SHALL drive mem_read=1 and i_or_d=1 and SHALL hold until mem_ready=1, then go to MEM_WB. MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-008 MEM_WR SHALL drive mem_write=1 and i_or_d=1 and SHALL hold until mem_ready=1, then go to FETCH. mem_write SHALL stay high for the whole wait.
REQ-009 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=100, then go to R_WB. R_WB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-010 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1 and pc_source=01, then go to FETCH.
REQ-011 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-012 I_EXEC SHALL drive alu_src_a=1 and alu_src_b=10, with alu_op=000 for ADDI and 011 for ANDI, then go to I_WB. I_WB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-013 The opcode SHALL be latched in DECODE, and later states SHALL use the latched copy so that a changing opcode input has no effect after DECODE.
REQ-014 Every output not named for a state SHALL be 0 in that state. Outputs SHALL be a combinational decode of state, latched opcode and mem_ready only, with no combinational path from opcode except illegal_op in DECODE.
REQ-015 Instruction latencies excluding memory waits SHALL be: lw 5, sw 4, R-type 4, addi/andi 4, beq 3, j 3 cycles.

Reset
REQ-016 With rst=1 at a rising edge, state SHALL become FETCH and the latched opcode 000000, regardless of mem_ready or the current state, including mid-wait in MEM_RD/MEM_WR.
REQ-017 While rst=1, all outputs SHALL be forced to 0 and state_dbg SHALL read the FETCH encoding (0).

Structure
REQ-018 The state encoding, opcode constants and alu_op codes SHALL live in a shared package, so that the ALU control stage uses the same alu_op values.
REQ-019 The state-to-output table SHALL be one combinational sub-module, mc_ctrl_decode. The state register and next-state logic SHALL stay in mc_control_fsm.

Verification
REQ-020 lw with mem_ready=1 always: states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; reg_write=1 only in MEM_WB.
REQ-021 sw with mem_ready=0 for 3 cycles in MEM_WR: mem_write=1 for exactly 4 cycles, then FETCH.
REQ-022 R-type (opcode 000000): alu_op=100 in R_EXEC; reg_dst=1 and reg_write=1 in R_WB; total 4 cycles.
REQ-023 beq: alu_op=001 and pc_write_cond=1 in BRANCH. andi: alu_op=011 in I_EXEC.
REQ-024 Opcode 111111: illegal_op=1 for one cycle in DECODE, next state FETCH, reg_write and mem_write never asserted.
REQ-025 rst=1 during a MEM_RD wait: next state FETCH, all outputs 0 while reset is held, and normal fetch resumes the cycle after rst falls.
